// File: rtl/clock_period_meter_pkg.sv
// ============================================================================
// Module      : clock_period_meter_pkg
// Description : Shared state encoding and default limits for the period meter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_e;

    localparam int c_cnt_w_default      = 32;
    localparam int c_max_period_default = 200000;
    localparam int c_tol_default        = 2;

endpackage

`default_nettype wire

// File: rtl/edge_sync.sv
// ============================================================================
// Module      : edge_sync
// Description : Two-flop synchronizer plus one delay flop for rising-edge detect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_sync
    import clock_period_meter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic d_in,
    output logic rise
);

    logic r_meta_q;
    logic r_sync_q;
    logic r_sync_dly_q;
    logic w_meta_d;
    logic w_sync_d;
    logic w_sync_dly_d;

    always_comb begin
        w_meta_d     = d_in;
        w_sync_d     = r_meta_q;
        w_sync_dly_d = r_sync_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta_q     <= 1'b0;
            r_sync_q     <= 1'b0;
            r_sync_dly_q <= 1'b0;
        end else begin
            r_meta_q     <= w_meta_d;
            r_sync_q     <= w_sync_d;
            r_sync_dly_q <= w_sync_dly_d;
        end
    end

    assign rise = r_sync_q & ~r_sync_dly_q;

endmodule

`default_nettype wire

// File: rtl/clock_period_meter.sv
// ============================================================================
// Module      : clock_period_meter
// Description : Measures rising-to-rising period of a slow input in clock
//               cycles, with timeout detection and period-to-period lock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_period_meter
    import clock_period_meter_pkg::*;
#(
    parameter int CNT_W      = c_cnt_w_default,
    parameter int MAX_PERIOD = c_max_period_default,
    parameter int TOL        = c_tol_default
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             timeout,
    output logic             locked
);

    localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] c_tol = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic             w_rise;
    state_e           r_state_q,     w_state_d;
    logic [CNT_W-1:0] r_cnt_q,       w_cnt_d;
    logic [CNT_W-1:0] r_period_q,    w_period_d;
    logic [CNT_W-1:0] r_prev_q,      w_prev_d;
    logic             r_valid_q,     w_valid_d;
    logic             r_timeout_q,   w_timeout_d;
    logic             r_locked_q,    w_locked_d;
    logic             r_have_prev_q, w_have_prev_d;
    logic [CNT_W-1:0] w_diff;

    edge_sync u_edge_sync (
        .clock (clock),
        .reset (reset),
        .d_in  (sig_in),
        .rise  (w_rise)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_period_d    = r_period_q;
        w_prev_d      = r_prev_q;
        w_valid_d     = 1'b0;
        w_timeout_d   = r_timeout_q;
        w_locked_d    = r_locked_q;
        w_have_prev_d = r_have_prev_q;
        w_diff        = (r_cnt_q >= r_prev_q) ? (r_cnt_q - r_prev_q)
                                              : (r_prev_q - r_cnt_q);

        case (r_state_q)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_d = ST_MEASURE;
                    w_cnt_d   = c_one;
                end
            end
            ST_MEASURE: begin
                // A rise coinciding with the limit still yields a valid period.
                if (w_rise) begin
                    w_period_d    = r_cnt_q;
                    w_prev_d      = r_cnt_q;
                    w_valid_d     = 1'b1;
                    w_cnt_d       = c_one;
                    w_locked_d    = r_have_prev_q && (w_diff <= c_tol);
                    w_have_prev_d = 1'b1;
                end else if (r_cnt_q == c_max) begin
                    w_state_d     = ST_TIMEOUT;
                    w_timeout_d   = 1'b1;
                    w_locked_d    = 1'b0;
                    w_have_prev_d = 1'b0;
                end else begin
                    w_cnt_d = r_cnt_q + c_one;
                end
            end
            ST_TIMEOUT: begin
                if (w_rise) begin
                    w_state_d   = ST_MEASURE;
                    w_cnt_d     = c_one;
                    w_timeout_d = 1'b0;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q     <= ST_IDLE;
            r_cnt_q       <= '0;
            r_period_q    <= '0;
            r_prev_q      <= '0;
            r_valid_q     <= 1'b0;
            r_timeout_q   <= 1'b0;
            r_locked_q    <= 1'b0;
            r_have_prev_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_period_q    <= w_period_d;
            r_prev_q      <= w_prev_d;
            r_valid_q     <= w_valid_d;
            r_timeout_q   <= w_timeout_d;
            r_locked_q    <= w_locked_d;
            r_have_prev_q <= w_have_prev_d;
        end
    end

    assign period_out   = r_period_q;
    assign period_valid = r_valid_q;
    assign timeout      = r_timeout_q;
    assign locked       = r_locked_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_period_meter.sv
// ============================================================================
// Module      : tb_clock_period_meter
// Description : Directed self-checking bench for clock_period_meter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_period_meter;

    localparam int CNT_W      = 16;
    localparam int MAX_PERIOD = 200;
    localparam int TOL        = 2;

    logic             clock;
    logic             reset;
    logic             sig_in;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             timeout;
    logic             locked;

    int total;
    int bad;

    typedef struct {
        int   gap;
        logic to_pre;
        logic valid;
        int   period;
        logic lock;
    } vec_t;

    vec_t vecs[17];

    clock_period_meter #(
        .CNT_W      (CNT_W),
        .MAX_PERIOD (MAX_PERIOD),
        .TOL        (TOL)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sig_in       (sig_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .timeout      (timeout),
        .locked       (locked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input int id, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL v%0d_%s: got %0d expected %0d", id, name, act, exp);
        end
    endtask

    task automatic chk_zero(input int id);
        chk(id, "rst_period", 32'(period_out), 32'd0);
        chk(id, "rst_valid",  32'(period_valid), 32'd0);
        chk(id, "rst_timeout", 32'(timeout), 32'd0);
        chk(id, "rst_locked", 32'(locked), 32'd0);
    endtask

    // Rise is launched gap negedges after the previous one; the meter reacts
    // three edges later, so outputs are sampled at launch+2, +3 and +4.
    task automatic rise_check(input int id, input int gap, input logic rel,
                              input logic to_pre, input logic v,
                              input int per, input logic lk);
        repeat (gap - 4) @(negedge clock);
        sig_in = 1'b1;
        if (rel) reset = 1'b0;
        @(negedge clock);
        sig_in = 1'b0;
        @(negedge clock);
        chk(id, "pre_valid",   32'(period_valid), 32'd0);
        chk(id, "pre_timeout", 32'(timeout), 32'(to_pre));
        @(negedge clock);
        chk(id, "valid",   32'(period_valid), 32'(v));
        chk(id, "period",  32'(period_out), 32'(per));
        chk(id, "locked",  32'(locked), 32'(lk));
        chk(id, "timeout", 32'(timeout), 32'd0);
        @(negedge clock);
        chk(id, "post_valid", 32'(period_valid), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        sig_in = 1'b0;

        vecs[0]  = '{10,  1'b0, 1'b0, 0,   1'b0};
        vecs[1]  = '{20,  1'b0, 1'b1, 20,  1'b0};
        vecs[2]  = '{21,  1'b0, 1'b1, 21,  1'b1};
        vecs[3]  = '{23,  1'b0, 1'b1, 23,  1'b1};
        vecs[4]  = '{26,  1'b0, 1'b1, 26,  1'b0};
        vecs[5]  = '{26,  1'b0, 1'b1, 26,  1'b1};
        vecs[6]  = '{5,   1'b0, 1'b1, 5,   1'b0};
        vecs[7]  = '{200, 1'b0, 1'b1, 200, 1'b0};
        vecs[8]  = '{198, 1'b0, 1'b1, 198, 1'b1};
        vecs[9]  = '{10,  1'b0, 1'b1, 10,  1'b0};
        vecs[10] = '{15,  1'b0, 1'b1, 15,  1'b0};
        vecs[11] = '{201, 1'b1, 1'b0, 15,  1'b0};
        vecs[12] = '{15,  1'b0, 1'b1, 15,  1'b0};
        vecs[13] = '{16,  1'b0, 1'b1, 16,  1'b1};
        vecs[14] = '{300, 1'b1, 1'b0, 16,  1'b0};
        vecs[15] = '{7,   1'b0, 1'b1, 7,   1'b0};
        vecs[16] = '{9,   1'b0, 1'b1, 9,   1'b1};

        repeat (3) @(negedge clock);
        chk_zero(100);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            rise_check(i, vecs[i].gap, 1'b0, vecs[i].to_pre,
                       vecs[i].valid, vecs[i].period, vecs[i].lock);
        end

        // One-cycle reset in the middle of a measurement.
        repeat (20) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_zero(200);
        rise_check(201, 10, 1'b0, 1'b0, 1'b0, 0,  1'b0);
        rise_check(202, 30, 1'b0, 1'b0, 1'b1, 30, 1'b0);

        // Input held high through reset: release acts as the first edge.
        repeat (10) @(negedge clock);
        sig_in = 1'b1;
        reset  = 1'b1;
        repeat (3) @(negedge clock);
        chk_zero(300);
        rise_check(301, 4,  1'b1, 1'b0, 1'b0, 0,  1'b0);
        rise_check(302, 12, 1'b0, 1'b0, 1'b1, 12, 1'b0);
        rise_check(303, 12, 1'b0, 1'b0, 1'b1, 12, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
